// File: rtl/sid_bus_responder.sv
// sid_bus_responder: bus-side SID 6581 register endpoint.
// Decodes phi2-sampled chip-select accesses into a 25-entry register file.
module sid_bus_responder #(
  parameter logic [15:0] DECAY_CYCLES = 16'd2048,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       NOTRES,
  input  logic       SID_CLK,
  input  logic       SID_NOTCS,
  input  logic       SID_RW,
  input  logic [4:0] SID_ADDR,
  input  logic [7:0] SID_DATA_IN,
  output logic [7:0] SID_DATA_OUT,
  output logic       SID_DATA_OE,
  input  logic [7:0] POTX_IN,
  input  logic [7:0] POTY_IN,
  input  logic [7:0] OSC3_IN,
  input  logic [7:0] ENV3_IN,
  output logic       WR_STB,
  output logic [4:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  input  logic [4:0] REG_RADDR,
  output logic [7:0] REG_RDATA,
  output logic [2:0] GATE,
  output logic [2:0] GATE_ON_STB,
  output logic [2:0] GATE_OFF_STB,
  output logic [3:0] MASTER_VOL
);

  typedef enum logic [1:0] {
    IDLE,
    SELECTED,
    COMMIT
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] rw_sync;

  logic       clk_s, cs_n_s, rw_s;
  logic       clk_d, fall;
  logic       do_cap, do_commit, do_wr;
  logic       rd_cond;
  logic       cap_rw;
  logic [4:0] cap_addr;
  logic [7:0] cap_data;
  logic [7:0] bus_latch;
  logic [15:0] decay;
  logic [7:0] rd_mux;
  logic [2:0] gate_new;

  logic [7:0] regs [25];

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign cs_n_s = cs_sync[SYNC_STAGES-1];
  assign rw_s   = rw_sync[SYNC_STAGES-1];
  assign fall   = clk_d & ~clk_s;
  assign do_wr  = do_commit & ~cap_rw;
  assign rd_cond = ~cs_n_s & rw_s;

  assign gate_new = {regs[18][0], regs[11][0], regs[4][0]};

  // synchronize the asynchronous bus controls and keep last phi2 sample
  always_ff @(posedge CLK or negedge NOTRES) begin
    if (!NOTRES) begin
      clk_sync <= '0;
      cs_sync  <= '0;
      rw_sync  <= '0;
      clk_d    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], SID_CLK};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], SID_NOTCS};
      rw_sync  <= {rw_sync[SYNC_STAGES-2:0], SID_RW};
      clk_d    <= clk_s;
    end
  end

  // access FSM state register
  always_ff @(posedge CLK or negedge NOTRES) begin
    if (!NOTRES) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // access FSM next state: each phi2 fall while selected is one access
  always_comb begin
    state_nx  = state;
    do_cap    = 1'b0;
    do_commit = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cs_n_s) state_nx = SELECTED;
      end
      SELECTED: begin
        if (cs_n_s) begin
          state_nx = IDLE;
        end else if (fall) begin
          state_nx = COMMIT;
          do_cap   = 1'b1;
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_nx  = cs_n_s ? IDLE : SELECTED;
      end
      default: state_nx = IDLE;
    endcase
  end

  // capture address/data/direction on the phi2 fall of an access
  always_ff @(posedge CLK or negedge NOTRES) begin
    if (!NOTRES) begin
      cap_rw   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else if (do_cap) begin
      cap_rw   <= rw_s;
      cap_addr <= SID_ADDR;
      cap_data <= SID_DATA_IN;
    end
  end

  // register file write and synth-core read port
  always_ff @(posedge CLK or negedge NOTRES) begin
    if (!NOTRES) begin
      for (int i = 0; i < 25; i++) regs[i] <= '0;
      REG_RDATA <= '0;
    end else begin
      REG_RDATA <= (REG_RADDR <= 5'd24) ? regs[REG_RADDR] : 8'h00;
      if (do_wr && cap_addr <= 5'd24) regs[cap_addr] <= cap_data;
    end
  end

  // write event strobe and last-write record
  always_ff @(posedge CLK or negedge NOTRES) begin
    if (!NOTRES) begin
      WR_STB  <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= '0;
    end else begin
      WR_STB <= do_wr;
      if (do_wr) begin
        WR_ADDR <= cap_addr;
        WR_DATA <= cap_data;
      end
    end
  end

  // bus latch and decay counter model the floating data bus
  always_ff @(posedge CLK or negedge NOTRES) begin
    if (!NOTRES) begin
      bus_latch <= '0;
      decay     <= '0;
    end else if (do_wr) begin
      bus_latch <= cap_data;
      decay     <= '0;
    end else if (fall && decay < DECAY_CYCLES) begin
      decay <= decay + 16'd1;
    end
  end

  // read-back source select
  always_comb begin
    rd_mux = (decay < DECAY_CYCLES) ? bus_latch : 8'h00;
    case (SID_ADDR)
      5'h19:   rd_mux = POTX_IN;
      5'h1A:   rd_mux = POTY_IN;
      5'h1B:   rd_mux = OSC3_IN;
      5'h1C:   rd_mux = ENV3_IN;
      default: ;
    endcase
  end

  // bus read driver
  always_ff @(posedge CLK or negedge NOTRES) begin
    if (!NOTRES) begin
      SID_DATA_OE  <= 1'b0;
      SID_DATA_OUT <= '0;
    end else begin
      SID_DATA_OE <= rd_cond;
      if (rd_cond) SID_DATA_OUT <= rd_mux;
    end
  end

  // synth-core control copies and gate edge strobes
  always_ff @(posedge CLK or negedge NOTRES) begin
    if (!NOTRES) begin
      GATE         <= '0;
      GATE_ON_STB  <= '0;
      GATE_OFF_STB <= '0;
      MASTER_VOL   <= '0;
    end else begin
      GATE         <= gate_new;
      GATE_ON_STB  <= gate_new & ~GATE;
      GATE_OFF_STB <= GATE & ~gate_new;
      MASTER_VOL   <= regs[24][3:0];
    end
  end

endmodule

// File: tb/tb_sid_bus_responder.sv
// tb_sid_bus_responder: directed bench for sid_bus_responder.
// Register/latch model plus per-cycle output compare.
module tb_sid_bus_responder;

  logic       CLK = 1'b0;
  logic       NOTRES = 1'b0;
  logic       SID_CLK = 1'b0;
  logic       SID_NOTCS = 1'b1;
  logic       SID_RW = 1'b1;
  logic [4:0] SID_ADDR = '0;
  logic [7:0] SID_DATA_IN = '0;
  logic [7:0] POTX_IN = 8'h12;
  logic [7:0] POTY_IN = 8'h34;
  logic [7:0] OSC3_IN = 8'h00;
  logic [7:0] ENV3_IN = 8'h56;
  logic [4:0] REG_RADDR = '0;

  logic [7:0] SID_DATA_OUT;
  logic       SID_DATA_OE;
  logic       WR_STB;
  logic [4:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic [7:0] REG_RDATA;
  logic [2:0] GATE;
  logic [2:0] GATE_ON_STB;
  logic [2:0] GATE_OFF_STB;
  logic [3:0] MASTER_VOL;

  sid_bus_responder dut (
    .CLK(CLK),
    .NOTRES(NOTRES),
    .SID_CLK(SID_CLK),
    .SID_NOTCS(SID_NOTCS),
    .SID_RW(SID_RW),
    .SID_ADDR(SID_ADDR),
    .SID_DATA_IN(SID_DATA_IN),
    .SID_DATA_OUT(SID_DATA_OUT),
    .SID_DATA_OE(SID_DATA_OE),
    .POTX_IN(POTX_IN),
    .POTY_IN(POTY_IN),
    .OSC3_IN(OSC3_IN),
    .ENV3_IN(ENV3_IN),
    .WR_STB(WR_STB),
    .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA),
    .REG_RADDR(REG_RADDR),
    .REG_RDATA(REG_RDATA),
    .GATE(GATE),
    .GATE_ON_STB(GATE_ON_STB),
    .GATE_OFF_STB(GATE_OFF_STB),
    .MASTER_VOL(MASTER_VOL)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial forever #5 CLK = ~CLK;

  // phi2 = CLK/16
  initial forever begin
    repeat (8) @(negedge CLK);
    SID_CLK = ~SID_CLK;
  end

  int cyc = 0;
  logic [4:0] raddr_cap = '0;
  always @(posedge CLK) begin
    cyc++;
    raddr_cap = REG_RADDR;
  end

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    int         t;
  } wr_t;

  wr_t wq[$];
  wr_t wn;
  wr_t w;

  logic [7:0] lat = '0;
  int since = 0;

  // bus-level access model: every phi2 fall with CS low is an access
  always @(negedge SID_CLK or negedge NOTRES) begin
    if (!NOTRES) begin
      lat = '0;
      since = 0;
    end else if (!SID_NOTCS && !SID_RW) begin
      wn.a = SID_ADDR;
      wn.d = SID_DATA_IN;
      wn.t = cyc;
      wq.push_back(wn);
      lat = SID_DATA_IN;
      since = 0;
    end else if (since < 2048) begin
      since++;
    end
  end

  logic [7:0] m [32];
  logic [2:0] gm;
  logic [2:0] g_prev = '0;
  int n_wr = 0;
  int n_on = 0;
  int n_off = 0;

  initial for (int i = 0; i < 32; i++) m[i] = '0;

  // per-cycle compare against the register model
  always @(negedge CLK) begin
    if (!NOTRES) begin
      chk("rst_data_out", SID_DATA_OUT, 0);
      chk("rst_oe", SID_DATA_OE, 0);
      chk("rst_wr_stb", WR_STB, 0);
      chk("rst_wr_addr", WR_ADDR, 0);
      chk("rst_wr_data", WR_DATA, 0);
      chk("rst_reg_rdata", REG_RDATA, 0);
      chk("rst_gate", GATE, 0);
      chk("rst_gate_on", GATE_ON_STB, 0);
      chk("rst_gate_off", GATE_OFF_STB, 0);
      chk("rst_master_vol", MASTER_VOL, 0);
      for (int i = 0; i < 32; i++) m[i] = '0;
      g_prev = '0;
    end else begin
      gm = {m[18][0], m[11][0], m[4][0]};
      chk("gate", GATE, gm);
      chk("gate_on", GATE_ON_STB, gm & ~g_prev);
      chk("gate_off", GATE_OFF_STB, g_prev & ~gm);
      chk("master_vol", MASTER_VOL, m[24][3:0]);
      chk("reg_rdata", REG_RDATA, m[raddr_cap]);
      g_prev = gm;
      if (wq.size() > 0 && cyc - wq[0].t > 8) begin
        chk("wr_stb_missing", 0, 1);
        void'(wq.pop_front());
      end
      if (WR_STB) begin
        n_wr++;
        if (wq.size() == 0) begin
          chk("wr_stb_spurious", 1, 0);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", WR_ADDR, w.a);
          chk("wr_data", WR_DATA, w.d);
          if (w.a <= 5'd24) m[w.a] = w.d;
        end
      end
      n_on  += int'(GATE_ON_STB[0]);
      n_off += int'(GATE_OFF_STB[0]);
    end
  end

  task automatic access(input logic rw, input logic [4:0] a,
                        input logic [7:0] d, input int n);
    @(posedge SID_CLK);
    SID_RW = rw;
    SID_ADDR = a;
    SID_DATA_IN = d;
    SID_NOTCS = 1'b0;
    repeat (n) @(negedge SID_CLK);
    @(posedge SID_CLK);
    SID_NOTCS = 1'b1;
    SID_RW = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp,
                    input string nm);
    @(posedge SID_CLK);
    SID_RW = 1'b1;
    SID_ADDR = a;
    SID_NOTCS = 1'b0;
    repeat (6) @(negedge CLK);
    chk({nm, "_oe"}, SID_DATA_OE, 1);
    chk(nm, SID_DATA_OUT, exp);
    if (a < 5'h19 || a > 5'h1C)
      chk({nm, "_model"}, SID_DATA_OUT, (since < 2048) ? lat : 8'h00);
    @(negedge SID_CLK);
    @(posedge SID_CLK);
    SID_NOTCS = 1'b1;
    repeat (4) @(negedge CLK);
    chk({nm, "_oe_off"}, SID_DATA_OE, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  int b_wr, b_on, b_off;

  initial begin
    repeat (5) @(negedge CLK);
    #1 NOTRES = 1'b1;

    // volume write
    REG_RADDR = 5'h18;
    b_wr = n_wr;
    access(1'b0, 5'h18, 8'h0F, 1);
    repeat (3) @(negedge CLK);
    chk("vol_wr_count", n_wr - b_wr, 1);
    chk("vol_wr_addr", WR_ADDR, 5'h18);
    chk("vol_wr_data", WR_DATA, 8'h0F);
    chk("vol_master", MASTER_VOL, 4'hF);
    chk("vol_rdata", REG_RDATA, 8'h0F);

    // gate on, rewrite, gate off
    REG_RADDR = 5'h04;
    b_on = n_on;
    b_off = n_off;
    access(1'b0, 5'h04, 8'h11, 1);
    repeat (2) @(negedge CLK);
    chk("gate0_set", GATE[0], 1);
    access(1'b0, 5'h04, 8'h11, 1);
    repeat (2) @(negedge CLK);
    chk("gate_rewrite_on", n_on - b_on, 1);
    access(1'b0, 5'h04, 8'h10, 1);
    repeat (2) @(negedge CLK);
    chk("gate_on_count", n_on - b_on, 1);
    chk("gate_off_count", n_off - b_off, 1);
    chk("gate0_clear", GATE[0], 0);

    // 64 back-to-back accesses under one CS
    b_wr = n_wr;
    access(1'b0, 5'h00, 8'h34, 64);
    REG_RADDR = 5'h00;
    repeat (3) @(negedge CLK);
    chk("burst_wr_count", n_wr - b_wr, 64);
    chk("burst_rdata", REG_RDATA, 8'h34);

    // read-only sources and bus decay
    OSC3_IN = 8'hA5;
    rd(5'h1B, 8'hA5, "rd_osc3");
    rd(5'h19, 8'h12, "rd_potx");
    access(1'b0, 5'h05, 8'h0F, 1);
    rd(5'h05, 8'h0F, "rd_decay_fresh");
    repeat (2050) @(negedge SID_CLK);
    rd(5'h05, 8'h00, "rd_decay_expired");

    // CS glitch with no phi2 fall
    b_wr = n_wr;
    @(posedge SID_CLK);
    @(negedge CLK);
    SID_RW = 1'b0;
    SID_ADDR = 5'h02;
    SID_DATA_IN = 8'h77;
    SID_NOTCS = 1'b0;
    repeat (3) @(negedge CLK);
    SID_NOTCS = 1'b1;
    SID_RW = 1'b1;
    repeat (2) @(negedge SID_CLK);
    chk("glitch_wr_count", n_wr - b_wr, 0);

    // register sweep against the model
    for (int i = 0; i < 32; i++) begin
      REG_RADDR = 5'(i);
      repeat (2) @(negedge CLK);
    end
    REG_RADDR = 5'h02;
    repeat (2) @(negedge CLK);
    chk("glitch_reg2", REG_RDATA, 8'h00);

    // reset in the middle of a write
    REG_RADDR = 5'h18;
    @(posedge SID_CLK);
    SID_RW = 1'b0;
    SID_ADDR = 5'h02;
    SID_DATA_IN = 8'h55;
    SID_NOTCS = 1'b0;
    repeat (3) @(negedge CLK);
    #1 NOTRES = 1'b0;
    repeat (2) @(negedge CLK);
    chk("midrst_master_vol", MASTER_VOL, 0);
    chk("midrst_wr_stb", WR_STB, 0);
    chk("midrst_rdata", REG_RDATA, 0);
    SID_NOTCS = 1'b1;
    SID_RW = 1'b1;
    @(negedge SID_CLK);
    repeat (2) @(negedge CLK);
    #1 NOTRES = 1'b1;
    b_wr = n_wr;
    access(1'b0, 5'h01, 8'h1F, 1);
    REG_RADDR = 5'h01;
    repeat (3) @(negedge CLK);
    chk("post_rst_wr_count", n_wr - b_wr, 1);
    chk("post_rst_rdata", REG_RDATA, 8'h1F);
    REG_RADDR = 5'h18;
    repeat (3) @(negedge CLK);
    chk("post_rst_vol_reg", REG_RDATA, 8'h00);
    for (int i = 0; i < 32; i++) begin
      REG_RADDR = 5'(i);
      repeat (2) @(negedge CLK);
    end

    repeat (12) @(negedge CLK);
    chk("wr_queue_empty", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
